// File: rtl/sigmacore_dmem_responder.sv
// Single-outstanding data-memory responder with a decoded base window and programmable wait states.
// Optional byte-lane stores are enabled by defining SIGMACORE_DMEM_WSTRB_EN.
module sigmacore_dmem_responder #(
    parameter logic [31:0] BASE_ADDR = 32'h1000_0000,
    parameter int          DEPTH     = 1024,
    parameter int          LATENCY   = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [15:0] txn_count
);

    localparam int          AW           = $clog2(DEPTH);
    localparam logic [31:0] WINDOW_BYTES = 32'(4 * DEPTH);
    localparam logic        ZERO_LAT     = (LATENCY == 0);
    localparam logic [3:0]  WAIT_INIT    = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t         state_r;
    state_t         state_next_s;
    logic [3:0]     wait_cnt_r;
    logic           we_r;
    logic           err_r;
    logic [AW-1:0]  idx_r;
    logic [31:0]    wdata_r;
    logic [3:0]     wstrb_r;
    logic [31:0]    mem_r [DEPTH];

    logic           accept_s;
    logic           commit_s;
    logic           rsp_fire_s;
    logic           addr_bad_s;
    logic [31:0]    offset_s;
    logic           cur_we_s;
    logic           cur_err_s;
    logic [AW-1:0]  cur_idx_s;
    logic [31:0]    cur_wdata_s;
    logic [3:0]     cur_wstrb_s;
    logic [3:0]     wmask_s;
    logic [31:0]    rdata_next_s;

    assign req_ready  = (state_r == ST_IDLE) && !reset;
    assign rsp_valid  = (state_r == ST_RESP);
    assign accept_s   = req_valid && req_ready;
    assign rsp_fire_s = (state_r == ST_RESP) && rsp_ready;

    // Addresses below the base wrap to large offsets, so one unsigned compare covers both bounds.
    assign offset_s   = req_addr - BASE_ADDR;
    assign addr_bad_s = (req_addr[1:0] != 2'b00) || (offset_s >= WINDOW_BYTES);

    // Next-state logic for the request/wait/response sequence.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_next_s = ZERO_LAT ? ST_RESP : ST_WAIT;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (wait_cnt_r == 4'd0) begin
                    state_next_s = ST_RESP;
                end else begin
                    state_next_s = ST_WAIT;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_RESP;
                end
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // With zero latency the commit edge is the accept edge, so take the live request fields.
    always_comb begin
        if (state_r == ST_IDLE) begin
            cur_we_s    = req_we;
            cur_err_s   = addr_bad_s;
            cur_idx_s   = offset_s[AW+1:2];
            cur_wdata_s = req_wdata;
            cur_wstrb_s = req_wstrb;
        end else begin
            cur_we_s    = we_r;
            cur_err_s   = err_r;
            cur_idx_s   = idx_r;
            cur_wdata_s = wdata_r;
            cur_wstrb_s = wstrb_r;
        end
    end

    // Commit control, byte mask and load data selection.
    always_comb begin
        commit_s = (state_next_s == ST_RESP) && (state_r != ST_RESP) && !reset;
`ifdef SIGMACORE_DMEM_WSTRB_EN
        wmask_s = cur_wstrb_s;
`else
        wmask_s = cur_wstrb_s | 4'b1111;
`endif
        if (!cur_we_s && !cur_err_s) begin
            rdata_next_s = mem_r[cur_idx_s];
        end else begin
            rdata_next_s = 32'h0000_0000;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Request latch, wait counter, response registers and handshake counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt_r <= 4'd0;
            we_r       <= 1'b0;
            err_r      <= 1'b0;
            idx_r      <= '0;
            wdata_r    <= 32'h0000_0000;
            wstrb_r    <= 4'b0000;
            rsp_rdata  <= 32'h0000_0000;
            rsp_err    <= 1'b0;
            txn_count  <= 16'h0000;
        end else begin
            if (accept_s) begin
                we_r       <= req_we;
                err_r      <= addr_bad_s;
                idx_r      <= offset_s[AW+1:2];
                wdata_r    <= req_wdata;
                wstrb_r    <= req_wstrb;
                wait_cnt_r <= WAIT_INIT;
            end else if ((state_r == ST_WAIT) && (wait_cnt_r != 4'd0)) begin
                wait_cnt_r <= wait_cnt_r - 4'd1;
            end
            if (commit_s) begin
                rsp_rdata <= rdata_next_s;
                rsp_err   <= cur_err_s;
            end
            if (rsp_fire_s) begin
                txn_count <= txn_count + 16'd1;
            end
        end
    end

    // Word RAM; contents survive reset and only good stores write it.
    always_ff @(posedge clk) begin
        if (commit_s && cur_we_s && !cur_err_s) begin
            for (int b = 0; b < 4; b++) begin
                if (wmask_s[b]) begin
                    mem_r[cur_idx_s][8*b +: 8] <= cur_wdata_s[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_sigmacore_dmem_responder.sv
// Randomized self-checking bench for sigmacore_dmem_responder against a word-array reference model.
module tb_sigmacore_dmem_responder;

    localparam logic [31:0] BASE = 32'h1000_0000;
    localparam int          LAT  = 2;

    logic        clk;
    logic        reset;
    logic        req_valid, req_ready, req_we;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_wstrb;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata;
    logic [15:0] txn_count;

    logic        req_valid0, req_ready0, req_we0;
    logic [31:0] req_addr0, req_wdata0;
    logic [3:0]  req_wstrb0;
    logic        rsp_valid0, rsp_ready0, rsp_err0;
    logic [31:0] rsp_rdata0;
    logic [15:0] txn_count0;

    int          checks;
    int          errors;
    int          model_cnt;
    logic [31:0] model_mem [0:1023];

    sigmacore_dmem_responder #(.BASE_ADDR(BASE), .DEPTH(1024), .LATENCY(LAT)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb), .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .txn_count(txn_count)
    );

    sigmacore_dmem_responder #(.BASE_ADDR(BASE), .DEPTH(1024), .LATENCY(0)) dut0 (
        .clk(clk), .reset(reset), .req_valid(req_valid0), .req_ready(req_ready0), .req_we(req_we0),
        .req_addr(req_addr0), .req_wdata(req_wdata0), .req_wstrb(req_wstrb0), .rsp_valid(rsp_valid0),
        .rsp_ready(rsp_ready0), .rsp_rdata(rsp_rdata0), .rsp_err(rsp_err0), .txn_count(txn_count0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic is_bad(input logic [31:0] a);
        return (a[1:0] != 2'b00) || (a < BASE) || (a >= BASE + 32'd4096);
    endfunction

    function automatic int word_of(input logic [31:0] a);
        return int'((a - BASE) >> 2) % 1024;
    endfunction

    // One complete transaction on the LATENCY=2 instance; stall = cycles rsp_ready is held low.
    task automatic do_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] wstrb, input int stall, output logic [31:0] got);
        logic [31:0] exp_rd;
        logic        exp_err;
        int          n;
        int          w;
        exp_err = is_bad(addr);
        w       = word_of(addr);
        exp_rd  = 32'h0000_0000;
        if (!exp_err) begin
            if (we) begin
`ifdef SIGMACORE_DMEM_WSTRB_EN
                for (int b = 0; b < 4; b++)
                    if (wstrb[b]) model_mem[w][8*b +: 8] = wdata[8*b +: 8];
`else
                model_mem[w] = wdata;
`endif
            end else begin
                exp_rd = model_mem[w];
            end
        end
        @(negedge clk);
        check_val("ready_idle", 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_wstrb = wstrb;
        @(posedge clk);
        #1;
        req_valid = 1'b0; req_we = 1'($urandom); req_addr = $urandom;
        req_wdata = $urandom; req_wstrb = 4'($urandom);
        n = 0;
        while (n < 40) begin
            @(negedge clk);
            n++;
            if (rsp_valid) break;
            check_val("ready_busy", 32'(req_ready), 32'd0);
        end
        got = rsp_rdata;
        if (!rsp_valid) begin
            check_val("rsp_timeout", 32'(rsp_valid), 32'd1);
            return;
        end
        check_val("latency", 32'(n), 32'(LAT + 1));
        check_val("rsp_err", 32'(rsp_err), 32'(exp_err));
        check_val("rsp_rdata", rsp_rdata, exp_rd);
        check_val("txn_before", 32'(txn_count), 32'(model_cnt[15:0]));
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            check_val("stall_valid", 32'(rsp_valid), 32'd1);
            check_val("stall_rdata", rsp_rdata, exp_rd);
            check_val("stall_err", 32'(rsp_err), 32'(exp_err));
            check_val("stall_ready", 32'(req_ready), 32'd0);
            check_val("stall_txn", 32'(txn_count), 32'(model_cnt[15:0]));
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        model_cnt++;
        @(negedge clk);
        check_val("txn_after", 32'(txn_count), 32'(model_cnt[15:0]));
        check_val("rsp_dropped", 32'(rsp_valid), 32'd0);
        check_val("ready_after", 32'(req_ready), 32'd1);
    endtask

    logic [31:0] got;
    logic [31:0] pool [8];
    logic [31:0] exp0;
    int          last_acc;
    int          k;

    initial begin
        checks = 0; errors = 0; model_cnt = 0;
        reset = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_addr = 32'h0; req_wdata = 32'h0; req_wstrb = 4'h0;
        rsp_ready = 1'b0;
        req_valid0 = 1'b0; req_we0 = 1'b0; req_addr0 = 32'h0; req_wdata0 = 32'h0; req_wstrb0 = 4'h0;
        rsp_ready0 = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("rst_ready", 32'(req_ready), 32'd0);
        check_val("rst_valid", 32'(rsp_valid), 32'd0);
        check_val("rst_rdata", rsp_rdata, 32'd0);
        check_val("rst_err", 32'(rsp_err), 32'd0);
        check_val("rst_txn", 32'(txn_count), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check_val("rst_ready_rel", 32'(req_ready), 32'd1);

        // Zero-latency instance: req_valid and rsp_ready held high, store/load pairs.
        rsp_ready0 = 1'b1;
        last_acc = -1; k = 0; exp0 = 32'h0;
        for (int cyc = 0; cyc < 24; cyc++) begin
            if (rsp_valid0) begin
                check_val("l0_latency", 32'(cyc - last_acc), 32'd1);
                check_val("l0_rdata", rsp_rdata0, exp0);
                check_val("l0_err", 32'(rsp_err0), 32'd0);
            end
            if (req_ready0) begin
                if (last_acc >= 0) check_val("l0_spacing", 32'(cyc - last_acc), 32'd2);
                req_valid0 = 1'b1;
                req_we0    = (k % 2 == 0);
                req_addr0  = BASE + 32'(4 * (100 + k / 2));
                req_wdata0 = (k % 2 == 0) ? 32'hA5A5_0000 + 32'(k) : $urandom;
                req_wstrb0 = 4'hF;
                exp0       = (k % 2 == 0) ? 32'h0 : 32'hA5A5_0000 + 32'(k - 1);
                last_acc   = cyc;
                k++;
            end
            @(negedge clk);
        end
        req_valid0 = 1'b0;
        check_val("l0_accepts", 32'(k), 32'd12);

        // Directed cases on the LATENCY=2 instance.
        do_txn(1'b1, 32'h1000_0FF8, 32'h2000_2123, 4'hF, 0, got);
        do_txn(1'b0, 32'h1000_0FF8, 32'h0, 4'hF, 4, got);
        check_val("word_3fe", got, 32'h2000_2123);
        do_txn(1'b1, 32'h1000_0000, 32'h1122_3344, 4'hF, 0, got);
        do_txn(1'b0, 32'h1000_1000, 32'h0, 4'hF, 1, got);
        do_txn(1'b1, 32'h1000_0002, 32'h5555_5555, 4'hF, 0, got);
        do_txn(1'b0, 32'h0FFF_FFFC, 32'h0, 4'hF, 0, got);
        do_txn(1'b0, 32'h1000_0000, 32'h0, 4'hF, 0, got);
        check_val("word0_kept", got, 32'h1122_3344);
        do_txn(1'b1, 32'h1000_0000, 32'hAABB_CCDD, 4'b0101, 0, got);
        do_txn(1'b0, 32'h1000_0000, 32'h0, 4'hF, 2, got);
`ifdef SIGMACORE_DMEM_WSTRB_EN
        check_val("wstrb_word", got, 32'h11BB_33DD);
`else
        check_val("wstrb_word", got, 32'hAABB_CCDD);
`endif

        // Random traffic over a pool of edge-of-window words plus bad addresses.
        for (int i = 0; i < 8; i++) begin
            pool[i] = BASE + 32'(4 * ((i < 4) ? i : 1016 + i));
            do_txn(1'b1, pool[i], $urandom, 4'hF, 0, got);
        end
        for (int i = 0; i < 40; i++) begin
            logic [31:0] a;
            a = pool[$urandom_range(0, 7)];
            case ($urandom_range(0, 7))
                0: a = BASE + 32'd4096 + 32'(4 * $urandom_range(0, 3));
                1: a = BASE - 32'd4;
                2: a = a + 32'($urandom_range(1, 3));
                default: a = a;
            endcase
            do_txn(1'($urandom), a, $urandom, 4'($urandom), $urandom_range(0, 3), got);
        end

        // Reset while a store sits in WAIT: it must never reach RAM.
        do_txn(1'b1, 32'h1000_0000, 32'h0BAD_F00D, 4'hF, 0, got);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h1000_0000;
        req_wdata = 32'hDEAD_BEEF; req_wstrb = 4'hF;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_cnt = 0;
        @(negedge clk);
        check_val("midrst_valid", 32'(rsp_valid), 32'd0);
        check_val("midrst_txn", 32'(txn_count), 32'd0);
        repeat (4) @(negedge clk);
        check_val("midrst_quiet", 32'(rsp_valid), 32'd0);
        do_txn(1'b0, 32'h1000_0000, 32'h0, 4'hF, 0, got);
        check_val("midrst_word", got, 32'h0BAD_F00D);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
